fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the three-stage RV32IS Z-Scale pipeline. It owns the fetch PC and drives the address input of the combinational instruction memory. It captures each returned word with its PC into a 2-entry prefetch queue, which feeds decode over a valid/ready handshake. It also handles branch/jump redirects from execute, fetch halt requests, and misaligned or out-of-range fetch faults.

---
 rtl/fetch_ctrl_pkg.sv | 19 +
 rtl/fetch_ctrl_queue.sv | 41 ++++
 rtl/fetch_ctrl.sv | 97 +++++++++
 tb/tb_fetch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

    localparam logic [31:0] START_OF_MEM = 32'h0000_1000;
    localparam logic [31:0] END_OF_MEM   = 32'h0000_1FFF;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_RUN    = 2'd0,
        FETCH_HALTED = 2'd1,
        FETCH_FAULT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_queue.sv
// Two-entry synchronous FIFO of {pc, instr}; flush empties it in one edge.
module fetch_queue
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [2];
    logic         r_head;
    logic         r_tail;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            // Full + pop + push writes the slot being vacated by the head.
            if (i_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != 2'd0) ? r_mem[r_head] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: drives imem, buffers words in a 2-deep queue for decode.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = START_OF_MEM,
    parameter logic [31:0] MEM_LO   = START_OF_MEM,
    parameter logic [31:0] MEM_HI   = END_OF_MEM
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        fetch_fault,
    output logic [1:0]  dbg_state
);

    fetch_state_e r_state;
    logic [31:0]  r_fpc;
    logic         r_fault;

    logic         w_legal;
    logic         w_pop_raw;
    logic         w_pop;
    logic         w_push;
    logic [1:0]   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_new;

    assign w_legal = (r_fpc[1:0] == 2'b00) && (r_fpc >= MEM_LO) &&
                     (r_fpc <= (MEM_HI - 32'd3));

    // A redirect squashes the head, so the handshake does not count as a pop.
    assign w_pop_raw = dec_valid && dec_ready;
    assign w_pop     = w_pop_raw && !redirect_valid;
    assign w_push    = (r_state == FETCH_RUN) && !halt && !redirect_valid &&
                       w_legal && ((w_count < 2'd2) || w_pop_raw);

    assign w_new.pc    = r_fpc;
    assign w_new.instr = imem_instr;

    fetch_queue u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_new),
        .o_count (w_count),
        .o_head  (w_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc   <= RESET_PC;
            r_state <= FETCH_RUN;
            r_fault <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_fpc <= redirect_pc;
            end else if (w_push) begin
                r_fpc <= r_fpc + 32'd4;
            end
            case (r_state)
                FETCH_RUN: begin
                    if (!w_legal && !redirect_valid) begin
                        r_state <= FETCH_FAULT;
                        r_fault <= 1'b1;
                    end else if (halt) begin
                        r_state <= FETCH_HALTED;
                    end
                end
                FETCH_HALTED: begin
                    if (!halt) begin
                        r_state <= FETCH_RUN;
                    end
                end
                FETCH_FAULT: r_state <= FETCH_FAULT;
                default:     r_state <= FETCH_RUN;
            endcase
        end
    end

    assign imem_addr   = r_fpc;
    assign dec_valid   = (w_count != 2'd0);
    assign dec_instr   = w_head.instr;
    assign dec_pc      = w_head.pc;
    assign fetch_fault = r_fault;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model plus delivery scoreboard.
module tb_fetch_ctrl;

    localparam logic [31:0] LO = 32'h0000_1000;
    localparam logic [31:0] HI = 32'h0000_10FF;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_fault;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    bit done   = 0;

    logic [63:0] exp_q[$];

    // Reference model: a plain queue of {pc, instr} plus mode flags.
    logic [63:0] m_q[$];
    logic [31:0] m_fpc;
    bit          m_halted;
    bit          m_faulted;

    fetch_ctrl #(.RESET_PC(LO), .MEM_LO(LO), .MEM_HI(HI)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fetch_fault    (fetch_fault),
        .dbg_state      (dbg_state)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == LO)               return 32'h0000_0011;
        else if (a == LO + 32'd4)  return 32'h0000_0022;
        else if (a == LO + 32'd8)  return 32'h0000_0033;
        else                       return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Compare the stable outputs, then advance the model across the coming edge.
    task automatic cycle(input bit rst, input bit hlt, input bit rv,
                         input logic [31:0] rpc, input bit rdy);
        bit legal;
        bit deliver;
        @(negedge clk);
        reset = rst; halt = hlt; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
        #1;
        check("dec_valid", {63'd0, dec_valid}, {63'd0, m_q.size() != 0});
        check("imem_addr", {32'd0, imem_addr}, {32'd0, m_fpc});
        check("fetch_fault", {63'd0, fetch_fault}, {63'd0, m_faulted});
        if (m_q.size() == 0)
            check("empty_head", {dec_pc, dec_instr}, 64'd0);
        if (rst) begin
            m_q.delete();
            m_fpc = LO; m_halted = 0; m_faulted = 0;
            return;
        end
        legal   = (m_fpc[1:0] == 2'b00) && (m_fpc >= LO) && (m_fpc <= HI - 32'd3);
        deliver = (m_q.size() != 0) && rdy && !rv;
        if (deliver) exp_q.push_back(m_q[0]);
        if (rv) begin
            m_q.delete();
            m_fpc = rpc;
        end else begin
            if (deliver) void'(m_q.pop_front());
            if (!m_halted && !m_faulted && !hlt && legal && m_q.size() < 2) begin
                m_q.push_back({m_fpc, mem_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
        if (!m_halted && !m_faulted) begin
            if (!legal && !rv) m_faulted = 1;
            else if (hlt)      m_halted = 1;
        end else if (m_halted && !hlt) begin
            m_halted = 0;
        end
    endtask

    // Monitor: every accepted handshake must match the next expected delivery.
    initial begin
        logic [63:0] e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (!reset && dec_valid && dec_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_delivery: got pc=%h instr=%h expected none", dec_pc, dec_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("delivery", {dec_pc, dec_instr}, e);
                end
            end
        end
    end

    initial begin
        reset = 1; halt = 0; redirect_valid = 0; redirect_pc = 0; dec_ready = 1;
        m_fpc = LO; m_halted = 0; m_faulted = 0;

        // Streaming from reset.
        repeat (2) cycle(1, 0, 0, 0, 1);
        repeat (6) cycle(0, 0, 0, 0, 1);
        // Backpressure saturates the queue, then drains without gaps.
        cycle(1, 0, 0, 0, 1);
        repeat (5) cycle(0, 0, 0, 0, 0);
        check("sat_addr", {32'd0, imem_addr}, {32'd0, LO + 32'd8});
        repeat (4) cycle(0, 0, 0, 0, 1);
        // Redirect while full with decode ready.
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, LO + 32'h40, 1);
        repeat (4) cycle(0, 0, 0, 0, 1);
        // Halt mid-stream.
        repeat (3) cycle(0, 1, 0, 0, 1);
        repeat (4) cycle(0, 0, 0, 0, 1);
        // Misaligned redirect faults; later legal redirect keeps the fault.
        cycle(0, 0, 1, LO + 32'h2, 1);
        repeat (3) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, LO + 32'h10, 1);
        repeat (3) cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 0, 1);
        // Run off the top of memory.
        cycle(0, 0, 1, HI - 32'd3 - 32'd8, 1);
        repeat (8) cycle(0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit rst, hlt, rv, rdy;
            logic [31:0] rpc;
            rst = ($urandom_range(0, 40) == 0);
            hlt = ($urandom_range(0, 7) == 0);
            rv  = ($urandom_range(0, 12) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       rpc = LO + 32'd2;
                1:       rpc = HI + 32'd1;
                2:       rpc = HI - 32'd3 - 32'd4;
                default: rpc = LO + {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            cycle(rst, hlt, rv, rpc, rdy);
        end

        cycle(0, 0, 0, 0, 0);
        done = 1;
        @(negedge clk);
        #3;
        check("scoreboard_drained", {32'd0, exp_q.size()}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
